// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus the IF/ID register outputs
// handed to decode and the immediate extender.
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH    = 10,
    parameter int unsigned INSTR_WIDTH = 9,
    parameter int unsigned IMM_WIDTH   = 3
);
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   if_valid;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;
    logic [IMM_WIDTH-1:0]   imm_field;
    logic                   imm_is_signed;

    modport master (
        output imem_addr,
        input  imem_data,
        output if_valid,
        output if_instr,
        output if_pc,
        output imm_field,
        output imm_is_signed
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  imm_field,
        input  imm_is_signed
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, start/halt sequencing,
// stall hold and branch redirect/flush.
module fetch_stage #(
    parameter int unsigned           PC_WIDTH    = 10,
    parameter int unsigned           INSTR_WIDTH = 9,
    parameter int unsigned           IMM_WIDTH   = 3,
    parameter int unsigned           SIGN_BIT    = 5,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'h1FF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    fetch_stage_if.master       bus,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;

    logic capture;
    logic is_halt;

    // A normal fetch happens only in RUN with no redirect and no stall.
    assign capture = (state_q == StRun) && !branch_taken && !stall;
    assign is_halt = (bus.imem_data == HALT_INSTR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StRun;
            StRun:    if (capture && is_halt) state_d = StHalted;
            StHalted: if (start) state_d = StRun;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (start) pc_d = '0;
            end
            StRun: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = bus.imem_data;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    // The HALT word freezes the PC on its own address.
                    if (!is_halt) pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            StHalted: begin
                done    = 1'b1;
                valid_d = 1'b0;
                if (start) pc_d = '0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            if_pc_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.if_valid      = valid_q;
    assign bus.if_instr      = instr_q;
    assign bus.if_pc         = if_pc_q;
    assign bus.imm_field     = instr_q[IMM_WIDTH-1:0];
    assign bus.imm_is_signed = instr_q[SIGN_BIT];

endmodule
